// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU with a sign-fix cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from the start edge.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] div_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [1:0]      op_q;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] dividend;
    logic [CW-1:0]   cnt;
    logic            q_neg;
    logic            r_neg;
    logic            div_zero;
    logic            ovf;

    logic            is_signed;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            start_zero;
    logic            start_ovf;
    logic            calc_last;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] fix_res;

    // Result forced by the RISC-V rules for divide-by-zero (zero=1) or signed overflow (zero=0).
    function automatic logic [XLEN-1:0] special_value(input logic [1:0] o,
                                                      input logic [XLEN-1:0] a,
                                                      input logic zero);
        if (zero)
            return o[1] ? a : '1;
        else
            return o[1] ? '0 : MIN_NEG;
    endfunction

    always_comb begin
        is_signed  = ~op[0];
        rs1_mag    = (is_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
        rs2_mag    = (is_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
        start_zero = (rs2_data == '0);
        start_ovf  = is_signed && (rs1_data == MIN_NEG) && (rs2_data == '1);
        calc_last  = (cnt == CW'(XLEN-1));
    end

    // The shifted remainder needs XLEN+1 bits; a set top bit of trial means it went negative.
    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        trial    = shifted - {1'b0, divisor};
        step_rem = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        step_quo = {quo[XLEN-2:0], ~trial[XLEN]};
    end

    always_comb begin
        fix_res = quo;
        if (div_zero || ovf) begin
            fix_res = special_value(op_q, dividend, div_zero);
        end else begin
            case (op_q)
                2'b00:   fix_res = q_neg ? -quo : quo;
                2'b01:   fix_res = quo;
                2'b10:   fix_res = r_neg ? -rem : rem;
                default: fix_res = rem;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
`ifdef DIV_EARLY_OUT_EN
                    next_state = (start_zero || start_ovf) ? DONE : CALC;
`else
                    next_state = CALC;
`endif
                end else begin
                    next_state = IDLE;
                end
            end
            CALC:    next_state = calc_last ? FIX : CALC;
            FIX:     next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC) || (state == FIX);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            dividend <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            div_out  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_q     <= op;
                        quo      <= rs1_mag;
                        divisor  <= rs2_mag;
                        dividend <= rs1_data;
                        rem      <= '0;
                        cnt      <= '0;
                        q_neg    <= rs1_data[XLEN-1] ^ rs2_data[XLEN-1];
                        r_neg    <= rs1_data[XLEN-1];
                        div_zero <= start_zero;
                        ovf      <= start_ovf;
`ifdef DIV_EARLY_OUT_EN
                        if (start_zero || start_ovf)
                            div_out <= special_value(op, rs1_data, start_zero);
`endif
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    div_out <= fix_res;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level latency model plus directed vectors with literal results.
// Honours DIV_EARLY_OUT_EN to select the expected timing of special cases.
`timescale 1ns/1ps
module tb_div_unit;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif
    localparam int SPEC_LAT  = EARLY ? 1 : 34;
    localparam int SPEC_BUSY = EARLY ? 0 : 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        busy;
    logic        done;
    logic [31:0] div_out;

    int checks = 0;
    int errors = 0;

    // Model state: busy cycles still to come, expected done and expected held result.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_out  = '0;
    logic [31:0] m_res  = '0;
    logic        armed  = 1'b0;

    div_unit #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .busy(busy),
        .done(done),
        .div_out(div_out)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension semantics written directly as arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'h0)
            r = o[1] ? a : 32'hFFFF_FFFF;
        else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            r = o[1] ? 32'h0 : 32'h8000_0000;
        else begin
            case (o)
                DIV:     r = $signed(a) / $signed(b);
                DIVU:    r = a / b;
                REM:     r = $signed(a) % $signed(b);
                default: r = a % b;
            endcase
        end
        return r;
    endfunction

    function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        op       = o;
        rs1_data = a;
        rs2_data = b;
    endtask

    // Accepted ops occupy 33 busy cycles and then raise done once, unless they finish early.
    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_out  <= '0;
            armed  <= 1'b1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_out  <= m_res;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                if (EARLY != 0 && is_special(op, rs1_data, rs2_data)) begin
                    m_done <= 1'b1;
                    m_out  <= ref_result(op, rs1_data, rs2_data);
                end else begin
                    m_res  <= ref_result(op, rs1_data, rs2_data);
                    m_left <= 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check_output("cmp_busy", {31'b0, busy}, {31'b0, m_left != 0});
            check_output("cmp_done", {31'b0, done}, {31'b0, m_done});
            check_output("cmp_div_out", div_out, m_out);
        end
    end

    // Launch at a negedge; latency counts cycles from the start cycle to the done cycle.
    task automatic run_case(input string name, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                            input int exp_busy, input int inject_at);
        int cyc;
        int bc;
        apply_stimulus(o, a, b);
        @(negedge clk);
        cyc = 1;
        bc  = 0;
        while (cyc <= 100) begin
            if (busy) bc++;
            if (done) break;
            if (inject_at != 0 && cyc == inject_at)
                apply_stimulus(DIVU, 32'd9, 32'd3);
            else
                start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_output({name, "_done_seen"}, {31'b0, done}, 32'd1);
        check_output({name, "_latency"}, cyc, exp_lat);
        check_output({name, "_busy_cycles"}, bc, exp_busy);
        check_output({name, "_result"}, div_out, exp);
    endtask

    initial begin
        int pulses;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        rs1_data = '0;
        rs2_data = '0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_done", {31'b0, done}, 32'd0);
        check_output("reset_div_out", div_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_case("divu_100_7", DIVU, 32'd100, 32'd7, 32'h0000_000E, 34, 33, 0);
        @(negedge clk);
        run_case("remu_100_7", REMU, 32'd100, 32'd7, 32'h0000_0002, 34, 33, 0);
        run_case("div_m100_7", DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 33, 0);
        run_case("rem_m100_7", REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 33, 0);
        run_case("rem_100_m7", REM, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 34, 33, 0);
        run_case("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 33, 0);
        run_case("remu_5_0", REMU, 32'd5, 32'd0, 32'h0000_0005, SPEC_LAT, SPEC_BUSY, 0);
        run_case("div_5_0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, SPEC_BUSY, 0);
        run_case("rem_m5_0", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPEC_LAT, SPEC_BUSY, 0);
        run_case("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, SPEC_BUSY, 0);
        run_case("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT, SPEC_BUSY, 0);
        run_case("divu_min_m1", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 33, 0);
        @(negedge clk);

        run_case("divu_50_5_ignored", DIVU, 32'd50, 32'd5, 32'd10, 34, 33, 10);
        run_case("divu_9_3_b2b", DIVU, 32'd9, 32'd3, 32'd3, 34, 33, 0);
        @(negedge clk);

        apply_stimulus(DIVU, 32'd1000, 32'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("midcalc_rst_busy", {31'b0, busy}, 32'd0);
        check_output("midcalc_rst_done", {31'b0, done}, 32'd0);
        check_output("midcalc_rst_div_out", div_out, 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_output("midcalc_rst_no_done", pulses, 32'd0);
        run_case("divu_8_2", DIVU, 32'd8, 32'd2, 32'd4, 34, 33, 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative sequential divider/remainder unit for the RISC-V core, implementing the M-extension DIV, DIVU, REM and REMU.
- The combinational ALU covers single-cycle ops. This block is the multi-cycle counterpart.
- The core starts it with a start pulse, stalls on busy, and retires the instruction on done.
- Radix-2 restoring algorithm on operand magnitudes, followed by a sign-fix cycle.

Parameters:
- XLEN, 32, operand/result width; the counter width is clog2(XLEN).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU; captured with start.
- rs1_data  input  XLEN  dividend; captured with start.
- rs2_data  input  XLEN  divisor; captured with start.
- busy  output  1  high in CALC and FIX.
- done  output  1  single-cycle pulse; div_out is valid in that cycle.
- div_out  output  XLEN  result; held until the next completion.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - busy=0, done=0, div_out=0; all internal registers cleared.
  - Reset wins over every other event, including mid-CALC; the in-flight op is discarded with no done pulse.
- States: IDLE, CALC, FIX, DONE.
  - busy = (state==CALC or FIX).
  - done = (state==DONE).
- IDLE or DONE with start=1:
  - Capture op.
  - Signed flag = (op==DIV or REM).
  - Load the dividend magnitude |rs1| into the quotient shift register. Load |rs2| into the divisor register. Magnitudes apply only for signed ops; otherwise load the raw values.
  - Clear the remainder accumulator and the counter.
  - Record q_neg = sign(rs1) xor sign(rs2); record r_neg = sign(rs1).
  - Go to CALC.
- IDLE or DONE with start=0: go to / stay in IDLE.
- DONE always lasts exactly one cycle.
- CALC, one step per cycle:
  - {rem, quo} shifted left 1.
  - trial = rem - divisor, computed at XLEN+1 bits.
  - If trial is non-negative: rem = trial and the quotient LSB is 1. Otherwise rem is unchanged and the quotient LSB is 0.
  - After XLEN steps (counter == XLEN-1), go to FIX.
- FIX: write div_out, then go to DONE.
  - DIV: q_neg ? -quo : quo.
  - DIVU: quo.
  - REM: r_neg ? -rem : rem.
  - REMU: rem.
- Special cases, overriding FIX arithmetic:
  - Divisor 0: DIV and DIVU give all-ones; REM and REMU give the dividend unchanged.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Both special conditions are detected at the start capture and stored in flags.
- Latency: start sampled at edge E0 → CALC E1..E32 → FIX → done high in the cycle after edge E33 (34 cycles from the sample edge to done).
- Start while busy=1 is ignored: no capture, no error.
- Start during DONE is accepted, giving back-to-back operation with no idle gap.
- Operands may change freely after capture.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned; this is correct for the unsigned datapath.
- All arithmetic is modulo 2^XLEN except the XLEN+1-bit trial subtract.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed overflow bypass CALC and FIX.
  - At the start edge, the state goes directly to DONE with the special result in div_out.
  - done is high in the cycle after E0; busy stays 0.
  - Normal ops keep the 34-cycle latency.
- Undefined: special cases run the full CALC/FIX sequence with fixed 34-cycle latency. The FIX override supplies the result, identical to the defined case except for timing.

Test Plan:
- DIVU 100/7 and REMU 100/7 → 0x0000000E and 0x00000002 respectively; done exactly 34 cycles after start, busy high for 33 cycles.
- DIV 0xFFFFFF9C(-100)/7 → 0xFFFFFFF2(-14); REM with the same operands → 0xFFFFFFFE(-2); REM 100/-7 → 0x00000002.
- DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 5/0 → 0xFFFFFFFF. With DIV_EARLY_OUT_EN, each done follows start by 1 cycle; without it, by 34 cycles.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Start with DIVU 50/5, then pulse start with 9/3 at cycle 10 (ignored) → result 10. A new start asserted in the DONE cycle with 9/3 → 3 after a further 34 cycles.
- Assert rst at cycle 15 of CALC → busy=0, done=0, div_out=0 next cycle; no done pulse follows; a subsequent DIVU 8/2 → 4.
